// File: rtl/llc_req_sched_if.sv
// Request/issue bundle for llc_req_sched: CPU push, snoop push and LLC issue handshakes.
// The master side feeds requests and models the LLC; the slave side is the scheduler.
interface llc_req_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int OP_WIDTH   = 4
);
    logic                  cpu_valid;
    logic                  cpu_ready;
    logic [OP_WIDTH-1:0]   cpu_op;
    logic [ADDR_WIDTH-1:0] cpu_addr;

    logic                  snp_valid;
    logic                  snp_ready;
    logic [OP_WIDTH-1:0]   snp_op;
    logic [ADDR_WIDTH-1:0] snp_addr;

    logic                  llc_valid;
    logic                  llc_ready;
    logic [OP_WIDTH-1:0]   llc_op;
    logic [ADDR_WIDTH-1:0] llc_addr;
    logic                  llc_done;

    modport master (
        output cpu_valid, cpu_op, cpu_addr, input cpu_ready,
        output snp_valid, snp_op, snp_addr, input snp_ready,
        input  llc_valid, llc_op, llc_addr, output llc_ready, llc_done
    );

    modport slave (
        input  cpu_valid, cpu_op, cpu_addr, output cpu_ready,
        input  snp_valid, snp_op, snp_addr, output snp_ready,
        output llc_valid, llc_op, llc_addr, input llc_ready, llc_done
    );
endinterface

// File: rtl/llc_req_sched.sv
// LLC request scheduler: CPU and snoop FIFOs, snoop-priority arbitration with bounded
// CPU starvation, and a single-outstanding issue FSM towards the LLC.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | nothing in flight; arbitrate and pop a FIFO head if any
//   S_ISSUE | llc_valid high, op/addr held until llc_ready
//   S_WAIT  | op accepted by LLC, waiting for llc_done
module llc_req_sched #(
    parameter int ADDR_WIDTH      = 32,
    parameter int OP_WIDTH        = 4,
    parameter int QDEPTH          = 4,
    parameter int MAX_SNOOP_BURST = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    llc_req_sched_if.slave   bus,
    output logic             o_cpu_err,
    output logic             o_snp_err,
    output logic             o_busy
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(MAX_SNOOP_BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    function automatic logic f_cpu_legal(input logic [OP_WIDTH-1:0] op);
        return (op == OP_WIDTH'(0)) || (op == OP_WIDTH'(1)) || (op == OP_WIDTH'(2)) ||
               (op == OP_WIDTH'(8)) || (op == OP_WIDTH'(9));
    endfunction

    function automatic logic f_snp_legal(input logic [OP_WIDTH-1:0] op);
        return (op == OP_WIDTH'(3)) || (op == OP_WIDTH'(4)) ||
               (op == OP_WIDTH'(5)) || (op == OP_WIDTH'(6));
    endfunction

    logic [OP_WIDTH-1:0]   r_c_op   [QDEPTH];
    logic [ADDR_WIDTH-1:0] r_c_addr [QDEPTH];
    logic [OP_WIDTH-1:0]   r_s_op   [QDEPTH];
    logic [ADDR_WIDTH-1:0] r_s_addr [QDEPTH];
    logic [PW-1:0]         r_c_wp, r_c_rp, r_s_wp, r_s_rp;
    logic [CW-1:0]         r_c_cnt, r_s_cnt;

    state_t                r_state;
    logic [BW-1:0]         r_burst;
    logic [OP_WIDTH-1:0]   r_llc_op;
    logic [ADDR_WIDTH-1:0] r_llc_addr;
    logic                  r_cpu_err, r_snp_err;

    logic                  w_c_full, w_c_empty, w_s_full, w_s_empty;
    logic                  w_c_hs, w_s_hs, w_c_push, w_s_push;
    logic                  w_c_norm;
    logic                  w_gnt_c, w_gnt_s;
    state_t                w_nstate;
    logic [BW-1:0]         w_burst_nxt;

    assign w_c_full  = (r_c_cnt == CW'(QDEPTH));
    assign w_c_empty = (r_c_cnt == '0);
    assign w_s_full  = (r_s_cnt == CW'(QDEPTH));
    assign w_s_empty = (r_s_cnt == '0);

    assign bus.cpu_ready = !w_c_full;
    assign bus.snp_ready = !w_s_full;

    // Illegal ops still complete the handshake; they just never reach the FIFO.
    assign w_c_hs   = bus.cpu_valid && !w_c_full;
    assign w_s_hs   = bus.snp_valid && !w_s_full;
    assign w_c_push = w_c_hs && f_cpu_legal(bus.cpu_op);
    assign w_s_push = w_s_hs && f_snp_legal(bus.snp_op);

    // Only 0/1/2 reach the CPU FIFO besides 8/9, so "not maintenance" means normal.
    assign w_c_norm = !w_c_empty && (r_c_op[r_c_rp] != OP_WIDTH'(8)) &&
                      (r_c_op[r_c_rp] != OP_WIDTH'(9));

    always_comb begin
        w_nstate    = r_state;
        w_gnt_c     = 1'b0;
        w_gnt_s     = 1'b0;
        w_burst_nxt = r_burst;
        case (r_state)
            S_IDLE: begin
                if (!w_s_empty && w_c_norm && (r_burst == BW'(MAX_SNOOP_BURST))) begin
                    w_gnt_c     = 1'b1;
                    w_burst_nxt = '0;
                end else if (!w_s_empty) begin
                    w_gnt_s = 1'b1;
                    if (!w_c_norm)
                        w_burst_nxt = '0;
                    else if (r_burst != BW'(MAX_SNOOP_BURST))
                        w_burst_nxt = r_burst + BW'(1);
                end else if (!w_c_empty) begin
                    w_gnt_c     = 1'b1;
                    w_burst_nxt = '0;
                end
                if (w_gnt_c || w_gnt_s)
                    w_nstate = S_ISSUE;
            end
            S_ISSUE: if (bus.llc_ready) w_nstate = S_WAIT;
            S_WAIT:  if (bus.llc_done)  w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    // Storage needs no reset: the pointers and counts define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_c_push) begin
            r_c_op[r_c_wp]   <= bus.cpu_op;
            r_c_addr[r_c_wp] <= bus.cpu_addr;
        end
        if (w_s_push) begin
            r_s_op[r_s_wp]   <= bus.snp_op;
            r_s_addr[r_s_wp] <= bus.snp_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_burst    <= '0;
            r_c_wp     <= '0;
            r_c_rp     <= '0;
            r_c_cnt    <= '0;
            r_s_wp     <= '0;
            r_s_rp     <= '0;
            r_s_cnt    <= '0;
            r_llc_op   <= '0;
            r_llc_addr <= '0;
            r_cpu_err  <= 1'b0;
            r_snp_err  <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_burst   <= w_burst_nxt;
            r_cpu_err <= w_c_hs && !f_cpu_legal(bus.cpu_op);
            r_snp_err <= w_s_hs && !f_snp_legal(bus.snp_op);
            if (w_c_push) r_c_wp <= r_c_wp + PW'(1);
            if (w_s_push) r_s_wp <= r_s_wp + PW'(1);
            if (w_gnt_c)  r_c_rp <= r_c_rp + PW'(1);
            if (w_gnt_s)  r_s_rp <= r_s_rp + PW'(1);
            r_c_cnt <= r_c_cnt + CW'(w_c_push) - CW'(w_gnt_c);
            r_s_cnt <= r_s_cnt + CW'(w_s_push) - CW'(w_gnt_s);
            if (w_gnt_c) begin
                r_llc_op   <= r_c_op[r_c_rp];
                r_llc_addr <= r_c_addr[r_c_rp];
            end else if (w_gnt_s) begin
                r_llc_op   <= r_s_op[r_s_rp];
                r_llc_addr <= r_s_addr[r_s_rp];
            end
        end
    end

    assign bus.llc_valid = (r_state == S_ISSUE);
    assign bus.llc_op    = r_llc_op;
    assign bus.llc_addr  = r_llc_addr;
    assign o_cpu_err     = r_cpu_err;
    assign o_snp_err     = r_snp_err;
    assign o_busy        = (r_state != S_IDLE) || !w_c_empty || !w_s_empty;
endmodule

// File: tb/tb_llc_req_sched.sv
// Bench for llc_req_sched: directed scenarios plus random traffic, all checked against a
// transaction-level model of the two queues, the arbitration rules and the single op in flight.
module tb_llc_req_sched;
    localparam int AW  = 32;
    localparam int OW  = 4;
    localparam int QD  = 4;
    localparam int MSB = 3;

    typedef struct {
        logic [OW-1:0] op;
        logic [AW-1:0] addr;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    logic cpu_err, snp_err, busy;

    always #5 clk = ~clk;

    llc_req_sched_if #(.ADDR_WIDTH(AW), .OP_WIDTH(OW)) bus ();

    llc_req_sched #(
        .ADDR_WIDTH(AW), .OP_WIDTH(OW), .QDEPTH(QD), .MAX_SNOOP_BURST(MSB)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .o_cpu_err (cpu_err),
        .o_snp_err (snp_err),
        .o_busy    (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    entry_t     m_cq[$];
    entry_t     m_sq[$];
    entry_t     m_cur;
    bit         m_out, m_acc, m_cerr, m_serr;
    int         m_burst;
    logic [3:0] issue_log[$];
    logic       prev_valid = 1'b0;
    logic [3:0] cpu_ops[5] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
    logic [3:0] snp_ops[4] = '{4'd3, 4'd4, 4'd5, 4'd6};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit cpu_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
    endfunction

    function automatic bit snp_legal(input logic [3:0] op);
        return op inside {4'd3, 4'd4, 4'd5, 4'd6};
    endfunction

    // Snoops first; a waiting normal CPU op is forced after MSB back-to-back snoops.
    task automatic arbitrate();
        bit cn;
        cn = (m_cq.size() > 0) && (m_cq[0].op < 8);
        if (m_sq.size() > 0 && cn && m_burst == MSB) begin
            m_cur = m_cq.pop_front(); m_burst = 0; m_out = 1;
        end else if (m_sq.size() > 0) begin
            m_cur = m_sq.pop_front(); m_out = 1;
            m_burst = cn ? ((m_burst < MSB) ? m_burst + 1 : MSB) : 0;
        end else if (m_cq.size() > 0) begin
            m_cur = m_cq.pop_front(); m_burst = 0; m_out = 1;
        end
        m_acc = 0;
    endtask

    task automatic step();
        bit     s_rst, cv, sv, lr, ld, was_out, c_hs, s_hs;
        entry_t ce, se;
        s_rst = rst;
        cv = bus.cpu_valid; sv = bus.snp_valid; lr = bus.llc_ready; ld = bus.llc_done;
        ce = '{op: bus.cpu_op, addr: bus.cpu_addr};
        se = '{op: bus.snp_op, addr: bus.snp_addr};
        @(posedge clk);
        #1;
        if (s_rst) begin
            m_cq.delete(); m_sq.delete();
            m_out = 0; m_acc = 0; m_burst = 0; m_cerr = 0; m_serr = 0;
            chk("llc_op_rst", 64'(bus.llc_op), 64'(0));
            chk("llc_addr_rst", 64'(bus.llc_addr), 64'(0));
        end else begin
            c_hs = cv && (m_cq.size() < QD);
            s_hs = sv && (m_sq.size() < QD);
            was_out = m_out;
            if (m_out && m_acc && ld) begin
                m_out = 0; m_acc = 0;
            end else if (m_out && !m_acc && lr) begin
                m_acc = 1;
            end
            if (!was_out) arbitrate();
            m_cerr = c_hs && !cpu_legal(ce.op);
            m_serr = s_hs && !snp_legal(se.op);
            if (c_hs && cpu_legal(ce.op)) m_cq.push_back(ce);
            if (s_hs && snp_legal(se.op)) m_sq.push_back(se);
        end
        chk("llc_valid", 64'(bus.llc_valid), 64'(m_out && !m_acc));
        if (m_out && !m_acc) begin
            chk("llc_op", 64'(bus.llc_op), 64'(m_cur.op));
            chk("llc_addr", 64'(bus.llc_addr), 64'(m_cur.addr));
        end
        chk("cpu_err", 64'(cpu_err), 64'(m_cerr));
        chk("snp_err", 64'(snp_err), 64'(m_serr));
        chk("busy", 64'(busy), 64'(m_out || m_cq.size() > 0 || m_sq.size() > 0));
        chk("cpu_ready", 64'(bus.cpu_ready), 64'(m_cq.size() < QD));
        chk("snp_ready", 64'(bus.snp_ready), 64'(m_sq.size() < QD));
        if (bus.llc_valid && !prev_valid) issue_log.push_back(bus.llc_op);
        prev_valid = bus.llc_valid;
    endtask

    task automatic set_in(input bit cv, input logic [3:0] cop, input bit sv, input logic [3:0] sop,
                          input bit lr, input bit ld);
        bus.cpu_valid = cv; bus.cpu_op = cop; bus.cpu_addr = $urandom;
        bus.snp_valid = sv; bus.snp_op = sop; bus.snp_addr = $urandom;
        bus.llc_ready = lr; bus.llc_done = ld;
    endtask

    task automatic idle_steps(input int n, input bit lr, input bit ld);
        set_in(0, 4'd0, 0, 4'd0, lr, ld);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_log(input string tag, input int n, input logic [23:0] exp);
        logic [23:0] pk;
        pk = '0;
        chk({tag, "_count"}, 64'(issue_log.size()), 64'(n));
        for (int i = 0; i < n && i < issue_log.size(); i++) pk = {pk[19:0], issue_log[i]};
        chk(tag, 64'(pk), 64'(exp));
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 4'd0, 0, 4'd0, 0, 0);
        step(); step();
        rst = 1'b0;

        // Single CPU op, LLC ready at once, done a couple of cycles later.
        set_in(1, 4'd0, 0, 4'd0, 1, 0);
        bus.cpu_addr = 32'h0000_1000;
        step();
        idle_steps(2, 1, 0);
        idle_steps(4, 1, 1);

        // Fill the CPU FIFO behind a stalled LLC, then pop while still pushing.
        set_in(1, 4'd1, 0, 4'd0, 0, 0);
        for (int i = 0; i < 7; i++) begin bus.cpu_addr = $urandom; step(); end
        bus.llc_ready = 1'b1; step();
        bus.llc_done = 1'b1;
        for (int i = 0; i < 4; i++) begin bus.cpu_addr = $urandom; step(); end
        idle_steps(30, 1, 1);

        // Snoop burst bound: one CPU op1 against five snoop op4.
        issue_log.delete();
        set_in(1, 4'd1, 1, 4'd4, 1, 1);
        step();
        set_in(0, 4'd0, 1, 4'd4, 1, 1);
        for (int i = 0; i < 4; i++) begin bus.snp_addr = $urandom; step(); end
        idle_steps(25, 1, 1);
        chk_log("order_burst", 6, 24'h444144);

        // Maintenance barrier: op9 then op0 with two snoops.
        issue_log.delete();
        set_in(1, 4'd9, 1, 4'd3, 1, 1); step();
        set_in(1, 4'd0, 1, 4'd5, 1, 1); step();
        idle_steps(20, 1, 1);
        chk_log("order_barrier", 4, 24'h003590);

        // Illegal ops on both sides in the same cycle.
        issue_log.delete();
        set_in(1, 4'd5, 1, 4'd1, 1, 1); step();
        idle_steps(4, 1, 1);
        chk("illegal_issue_count", 64'(issue_log.size()), 64'(0));

        // Reset while an op is offered with two more queued.
        set_in(1, 4'd2, 0, 4'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin bus.cpu_addr = $urandom; step(); end
        idle_steps(1, 0, 0);
        rst = 1'b1; step(); rst = 1'b0;
        idle_steps(5, 1, 1);

        // Random traffic with occasional illegal ops and resets.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 1) == 1,
                   ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : cpu_ops[$urandom_range(0, 4)],
                   $urandom_range(0, 2) == 0,
                   ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : snp_ops[$urandom_range(0, 3)],
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle_steps(40, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/llc_req_sched.md
Name: llc_req_sched

Overview:
Request scheduler in front of the LLC datapath. It queues processor-side trace commands (ops 0,1,2,8,9) and snooped-bus commands (ops 3,4,5,6) in two FIFOs. It arbitrates between the queues and issues exactly one operation at a time to the LLC through a valid/ready/done handshake. Snoops have priority, with bounded starvation of the CPU side; clear/print ops (8/9) act as barriers.

Parameters:
ADDR_WIDTH, 32, address width
OP_WIDTH, 4, op code width (trace codes 0-9)
QDEPTH, 4, entries per FIFO (power of 2, >=2)
MAX_SNOOP_BURST, 3, max consecutive snoop grants while a CPU op (0/1/2) waits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_valid  in  1  CPU-side request valid
cpu_ready  out  1  CPU FIFO not full
cpu_op  in  OP_WIDTH  CPU op code
cpu_addr  in  ADDR_WIDTH  CPU address
snp_valid  in  1  snoop request valid
snp_ready  out  1  snoop FIFO not full
snp_op  in  OP_WIDTH  snoop op code
snp_addr  in  ADDR_WIDTH  snoop address
llc_valid  out  1  op offered to LLC
llc_ready  in  1  LLC accepts offered op
llc_op  out  OP_WIDTH  issued op
llc_addr  out  ADDR_WIDTH  issued address
llc_done  in  1  LLC finished accepted op
cpu_err  out  1  one-cycle pulse: illegal CPU op dropped
snp_err  out  1  one-cycle pulse: illegal snoop op dropped
busy  out  1  state != IDLE or either FIFO non-empty

Behaviour:
- Clock is clk; reset is synchronous, active-high, on rst. Reset values: llc_valid=0, llc_op=0, llc_addr=0, cpu_err=0, snp_err=0, busy=0, both FIFOs empty (cpu_ready=snp_ready=1), state=IDLE, burst counter=0.
- rst asserted mid-operation discards all queued and in-flight ops; llc_valid drops at the next edge. The LLC owns its own recovery.
- Push: handshake when valid && ready at an edge. ready = !full, combinational from occupancy only; a pop in the same cycle does not free space for a push.
- Op legality: CPU {0,1,2,8,9}, snoop {3,4,5,6}. An illegal op completes its handshake, is not queued, and raises the matching *_err for exactly one cycle at the next edge.
- FSM IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE: if a grant is available at the edge, pop the head, register llc_op/llc_addr, go to ISSUE.
  - ISSUE: llc_valid=1, with op/addr held stable until llc_ready=1 at an edge, then go to WAIT.
  - WAIT: llc_valid=0; on llc_done=1 go to IDLE. llc_done outside WAIT is ignored.
- Latency: an entry pushed at edge E can make llc_valid high at the earliest from edge E+1. There are at least 2 cycles between consecutive llc_valid rises.
- Arbitration in IDLE, with the CPU head classed as normal (0/1/2) or maintenance (8/9):
  1. Snoop queue non-empty and CPU head normal with burst counter == MAX_SNOOP_BURST: grant CPU, counter := 0.
  2. Else if snoop queue non-empty: grant snoop. Counter increments (saturating at MAX_SNOOP_BURST) only if CPU head is normal, else holds at 0.
  3. Else if CPU queue non-empty: grant CPU, counter := 0.
- Maintenance barrier: op 8/9 is granted only when the snoop queue is empty and the state is IDLE. Ops behind it in the CPU FIFO wait. The counter never forces a maintenance op.
- FIFO pointers are log2(QDEPTH) bits and wrap modulo QDEPTH. Occupancy is tracked with an extra bit so full and empty are distinguishable.
- busy is combinational.

Test Plan:
- Reset then CPU push op0 addr 0x0000_1000 at edge 1; LLC ready=1 immediately, done 2 cycles later -> llc_valid high for 1 cycle from edge 2 with op0/0x1000; busy drops after done.
- Fill CPU FIFO with 4 ops while llc_ready=0 -> cpu_ready=0 after 3rd in-flight+4 queued; 5th push refused; pop+push same cycle at full -> push still refused.
- CPU op1 queued plus 5 snoop op4 queued, LLC always ready and done the next cycle -> issue order S,S,S,C,S,S.
- CPU op9 at head with 2 snoops queued -> both snoops issued first, then op9. CPU op0 queued behind op9 issues only after op9's done.
- CPU push op5 and snoop push op1 in the same cycle -> cpu_err and snp_err both pulse 1 cycle; nothing issued; FIFOs stay empty.
- rst asserted while in ISSUE with 2 entries queued -> next edge llc_valid=0, FIFOs empty, busy=0; a subsequent llc_done is ignored.
